axis_block_detector: RTL
========================

Name: axis_block_detector

Overview:
- Generates the per-channel `axis_block_sigs` vector that the cosim deadlock monitors consume.
- Watches the tvalid/tready pair of every AXI-Stream port on the kernel under test.
- Flags a channel as blocked after a programmable run of consecutive stall cycles, and latches which channel blocked first for the deadlock report.
- Sits in the simulation wrapper between the DUT stream ports and the deadlock monitor tree.

Parameters:
- NUM_CH, 15: number of stream channels watched; sets the width of the block vector.
- DIR_MASK, 15'h0000: per channel; 0 = DUT reads the stream (input), 1 = DUT writes the stream (output).
- IGNORE_MASK, 15'h0003: per channel; 1 = channel is never flagged (its block bit is tied 0).
- THRESH_W, 16: width of the threshold and the stall counters.

Ports:
- clock  in  1  kernel clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = detection running; 0 = all channels forced to IDLE, counters 0.
- clear  in  1  one-cycle pulse; clears channel states, counters and the first-block record.
- threshold  in  THRESH_W  consecutive stall cycles needed to flag a channel; 0 is treated as 1.
- ch_tvalid  in  NUM_CH  tvalid of each watched stream.
- ch_tready  in  NUM_CH  tready of each watched stream.
- axis_block_sigs  out  NUM_CH  registered per-channel blocked flags.
- block_any  out  1  registered OR of axis_block_sigs.
- first_valid  out  1  high once any channel has been flagged since the last reset/clear.
- first_ch  out  $clog2(NUM_CH)  index of the first flagged channel; valid when first_valid=1.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All outputs go to 0.
  - Every channel goes to IDLE with count 0.
  - Reset takes priority over clear and enable.
- Stall condition per channel:
  - Input channel (DIR=0): ch_tready & ~ch_tvalid (DUT starved).
  - Output channel (DIR=1): ch_tvalid & ~ch_tready (DUT backpressured).
- Transfer condition: ch_tvalid & ch_tready. Neither stall nor transfer (both low) counts as idle.
- Per-channel FSM, states IDLE / STALL / BLOCKED:
  - IDLE:
    - On stall: count <= 1. Go to BLOCKED if the effective threshold is 1, else go to STALL.
    - Otherwise stay in IDLE.
  - STALL:
    - On stall: count increments. Go to BLOCKED when count+1 >= threshold.
    - On transfer or idle: go to IDLE, count <= 0.
  - BLOCKED:
    - Hold while stall persists; count saturates at all-ones.
    - On transfer or idle: go to IDLE, count <= 0. The block bit drops on the next edge.
- Output timing:
  - axis_block_sigs[i] = (state==BLOCKED), registered.
  - With threshold T, stall continuous from cycle 0: the bit is high from cycle T.
- Threshold changes mid-run:
  - Take effect on the next comparison.
  - A channel already in BLOCKED stays there regardless of the new threshold.
- Channels with IGNORE_MASK=1: FSM stays in IDLE and the bit is constant 0.
- enable=0: states and counts are forced to IDLE/0 every cycle. The first-block record is held.
- clear=1: same effect as enable=0 for that cycle, and also sets first_valid <= 0 and first_ch <= 0. clear takes priority over a simultaneous entry into BLOCKED.
- First-block capture:
  - On the cycle any channel transitions into BLOCKED while first_valid=0: first_valid <= 1 and first_ch <= lowest such index.
  - The record is sticky until reset or clear.
- block_any is the registered OR of the next-state block flags, so it is cycle-aligned with axis_block_sigs.

Decomposition:
- Shared package: chan_state_t enum (IDLE, STALL, BLOCKED), default THRESH_W, default masks, and a helper function for the stall condition.
- One sub-module, axis_block_chan: a single channel's FSM plus saturating counter.
  - Inputs: tvalid, tready, dir, threshold, enable, clear.
  - Outputs: blocked, enter_blocked pulse.
- The top level generates NUM_CH instances, applies the ignore mask, ORs the flags and contains the lowest-index priority encoder for first_ch.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, then release with threshold=4 and all streams idle → all outputs 0 for 20 cycles.
- Threshold latency: threshold=4; channel 2 (input) gets tready=1, tvalid=0 from cycle 0 → axis_block_sigs[2] rises at cycle 4, block_any with it; first_valid=1, first_ch=2.
- Recovery: in the previous state, drive tvalid=1 for one cycle → bit 2 falls the next cycle; stall again for 3 cycles → bit stays low; first_ch stays 2.
- Output backpressure plus simultaneous entry: DIR_MASK bit 5 and bit 9 set, threshold=1; at the same cycle both get tvalid=1, tready=0 → both bits high next cycle; first_ch=5.
- Ignore mask: stall channels 0 and 1 for 100 cycles at threshold=1 → bits 0 and 1 stay 0, first_valid stays 0.
- Control: with channel 3 blocked, pulse clear → all bits 0 and first_valid 0 the next cycle, and bit 3 re-asserts after threshold more stall cycles. With enable=0 and a stall held for 50 cycles → no bits set. Assert reset_n=0 mid-stall → all outputs 0 the next cycle.

Source files
------------

// File: rtl/axis_block_detector_pkg.sv
// Shared definitions for the AXI-Stream block detector.
//   chan_state_t    : per-channel FSM state (IDLE / STALL / BLOCKED)
//   DEF_*           : default channel count, counter width and masks
//   stall_cond()    : stall condition of one stream given its direction
package axis_block_detector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    BLOCKED = 2'd2
  } chan_state_t;

  localparam int          DEF_NUM_CH      = 15;
  localparam int          DEF_THRESH_W    = 16;
  localparam logic [14:0] DEF_DIR_MASK    = 15'h0000;
  localparam logic [14:0] DEF_IGNORE_MASK = 15'h0003;

  // dir=0: DUT consumes the stream, so it is stalled when starved.
  // dir=1: DUT produces the stream, so it is stalled when backpressured.
  function automatic logic stall_cond(input logic dir, input logic tvalid,
                                      input logic tready);
    return dir ? (tvalid & ~tready) : (tready & ~tvalid);
  endfunction

endpackage

// File: rtl/axis_block_detector_chan.sv
// Single-channel stall tracker: FSM plus saturating run-length counter.
//   clock, reset_n     : clock / synchronous active-low reset
//   tvalid, tready     : handshake pair of the watched stream
//   dir                : 0 = DUT input stream, 1 = DUT output stream
//   threshold          : stall cycles needed to flag (0 behaves as 1)
//   enable, clear      : either one forces IDLE with count 0
//   blocked            : registered state==BLOCKED
//   blocked_next       : next-state BLOCKED flag (for the registered OR)
//   enter_blocked      : next edge moves this channel into BLOCKED
module axis_block_chan
  import axis_block_detector_pkg::*;
#(
  parameter int THRESH_W = DEF_THRESH_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tvalid,
  input  logic                tready,
  input  logic                dir,
  input  logic [THRESH_W-1:0] threshold,
  input  logic                enable,
  input  logic                clear,
  output logic                blocked,
  output logic                blocked_next,
  output logic                enter_blocked
);

  chan_state_t         state, state_nxt;
  logic [THRESH_W-1:0] count, count_nxt;
  logic [THRESH_W-1:0] eff_thresh;
  logic [THRESH_W-1:0] count_sat;
  logic [THRESH_W:0]   count_p1;
  logic                stall;

  always_comb begin
    eff_thresh = (threshold == '0) ? THRESH_W'(1) : threshold;
    stall      = stall_cond(dir, tvalid, tready);
    // extra bit so count+1 cannot wrap when compared against the threshold
    count_p1   = {1'b0, count} + 1'b1;
    count_sat  = (count == '1) ? count : count_p1[THRESH_W-1:0];

    state_nxt = state;
    count_nxt = count;
    if (!enable || clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (stall) begin
            count_nxt = THRESH_W'(1);
            state_nxt = (eff_thresh == THRESH_W'(1)) ? BLOCKED : STALL;
          end
        end
        STALL: begin
          if (stall) begin
            count_nxt = count_sat;
            if (count_p1 >= {1'b0, eff_thresh}) state_nxt = BLOCKED;
          end else begin
            state_nxt = IDLE;
            count_nxt = '0;
          end
        end
        BLOCKED: begin
          // threshold is not re-evaluated here: once blocked, only a
          // break in the stall releases the channel
          if (stall) begin
            count_nxt = count_sat;
          end else begin
            state_nxt = IDLE;
            count_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
    blocked_next  = (state_nxt == BLOCKED);
    enter_blocked = blocked_next && (state != BLOCKED);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  assign blocked = (state == BLOCKED);

endmodule

// File: rtl/axis_block_detector.sv
// Per-channel blocked-stream detector feeding the cosim deadlock monitors.
//   clock, reset_n        : clock / synchronous active-low reset
//   enable                : 0 forces every channel to IDLE
//   clear                 : pulse; clears channels and first-block record
//   threshold             : consecutive stall cycles to flag (0 acts as 1)
//   ch_tvalid, ch_tready  : handshake pairs of the watched streams
//   axis_block_sigs       : registered per-channel blocked flags
//   block_any             : registered OR of axis_block_sigs
//   first_valid, first_ch : sticky record of the first channel to block
module axis_block_detector
  import axis_block_detector_pkg::*;
#(
  parameter int                NUM_CH      = DEF_NUM_CH,
  parameter logic [NUM_CH-1:0] DIR_MASK    = DEF_DIR_MASK,
  parameter logic [NUM_CH-1:0] IGNORE_MASK = DEF_IGNORE_MASK,
  parameter int                THRESH_W    = DEF_THRESH_W,
  localparam int               FCH_W       = $clog2(NUM_CH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clear,
  input  logic [THRESH_W-1:0] threshold,
  input  logic [NUM_CH-1:0]   ch_tvalid,
  input  logic [NUM_CH-1:0]   ch_tready,
  output logic [NUM_CH-1:0]   axis_block_sigs,
  output logic                block_any,
  output logic                first_valid,
  output logic [FCH_W-1:0]    first_ch
);

  logic [NUM_CH-1:0] blk, blk_nxt, enter;
  logic [FCH_W-1:0]  first_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // ignored channels are held disabled so their FSM never leaves IDLE
    axis_block_chan #(.THRESH_W(THRESH_W)) u_chan (
      .clock         (clock),
      .reset_n       (reset_n),
      .tvalid        (ch_tvalid[i]),
      .tready        (ch_tready[i]),
      .dir           (DIR_MASK[i]),
      .threshold     (threshold),
      .enable        (enable & ~IGNORE_MASK[i]),
      .clear         (clear),
      .blocked       (blk[i]),
      .blocked_next  (blk_nxt[i]),
      .enter_blocked (enter[i])
    );
  end

  assign axis_block_sigs = blk & ~IGNORE_MASK;

  // lowest index wins when several channels block on the same edge
  always_comb begin
    first_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i] && !IGNORE_MASK[i]) first_sel = FCH_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      block_any   <= 1'b0;
      first_valid <= 1'b0;
      first_ch    <= '0;
    end else begin
      block_any <= |(blk_nxt & ~IGNORE_MASK);
      if (clear) begin
        first_valid <= 1'b0;
        first_ch    <= '0;
      end else if (!first_valid && |(enter & ~IGNORE_MASK)) begin
        first_valid <= 1'b1;
        first_ch    <= first_sel;
      end
    end
  end

endmodule
